// File: rtl/serial_alu_core_pkg.sv
// rtl/serial_alu_core_pkg.sv - operation codes and FSM state encodings for serial_alu_core
package serial_alu_core_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_SEND     = 2'd2,
        ST_WAIT_CLR = 2'd3
    } state_e;

endpackage

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - WIDTH-step shift-add multiplier / restoring divider
module seq_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] q
);

    localparam int SCW = $clog2(WIDTH + 1);

    // r_acc: product (MUL) or remainder (DIV); r_sh: multiplicand or quotient/dividend;
    // r_opd: multiplier or divisor.
    logic [SCW-1:0]   r_cnt;
    logic             r_is_div;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_opd;

    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_sh_nxt;
    logic [WIDTH-1:0] w_opd_nxt;

    always_comb begin
        w_rem_sh  = {r_acc, r_sh[WIDTH-1]};
        w_acc_nxt = r_acc;
        w_sh_nxt  = r_sh;
        w_opd_nxt = r_opd;
        if (r_is_div) begin
            if (w_rem_sh >= {1'b0, r_opd}) begin
                w_acc_nxt = WIDTH'(w_rem_sh - {1'b0, r_opd});
                w_sh_nxt  = {r_sh[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_rem_sh[WIDTH-1:0];
                w_sh_nxt  = {r_sh[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_nxt = r_acc + (r_opd[0] ? r_sh : '0);
            w_sh_nxt  = r_sh << 1;
            w_opd_nxt = r_opd >> 1;
        end
    end

    // done flags the final step so the caller latches q on the same edge it completes.
    assign done = (r_cnt == SCW'(1));
    assign q    = r_is_div ? w_sh_nxt : w_acc_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_acc    <= '0;
            r_sh     <= '0;
            r_opd    <= '0;
        end else if (start) begin
            r_cnt    <= SCW'(WIDTH);
            r_is_div <= is_div;
            r_acc    <= '0;
            r_sh     <= a;
            r_opd    <= b;
        end else if (r_cnt != '0) begin
            r_cnt    <= r_cnt - SCW'(1);
            r_acc    <= w_acc_nxt;
            r_sh     <= w_sh_nxt;
            r_opd    <= w_opd_nxt;
        end
    end

endmodule

// File: rtl/serial_alu_core.sv
// rtl/serial_alu_core.sv - operand capture, ALU sequencing and held tx_en strobe
module serial_alu_core
    import serial_alu_core_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int TX_HOLD_CYCLES = 10416
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ready,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             tx_en,
    output logic             busy,
    output logic             div_zero
);

    localparam int             CW        = $clog2(TX_HOLD_CYCLES + 1);
    localparam logic [CW-1:0]  HOLD_LOAD = CW'(TX_HOLD_CYCLES);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    op_e              r_op;
    logic [CW-1:0]    r_hold_cnt;
    logic             r_tx_en;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_result;

    op_e              w_op_in;
    logic             w_capture;
    logic             w_md_start;
    logic             w_md_is_div;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_q;
    logic             w_div_by_zero;
    logic             w_exec_done;
    logic             w_tx_en_d;

    assign w_op_in       = op_e'(op);
    assign w_capture     = (r_state == ST_IDLE) && ready;
    assign w_md_is_div   = (w_op_in == OP_DIV);
    // The iterative unit is launched straight from the ports on the capture edge,
    // which is what brings MUL/DIV latency down to WIDTH+1.
    assign w_md_start    = w_capture && ((w_op_in == OP_MUL) || (w_md_is_div && (b != '0)));
    assign w_div_by_zero = (r_op == OP_DIV) && (r_b == '0);
    assign w_exec_done   = (r_op == OP_ADD) || (r_op == OP_SUB) || w_div_by_zero || w_md_done;

    seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_md_start),
        .is_div  (w_md_is_div),
        .a       (a),
        .b       (b),
        .done    (w_md_done),
        .q       (w_md_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (ready)             w_state_nxt = ST_EXEC;
            ST_EXEC:     if (w_exec_done)       w_state_nxt = ST_SEND;
            ST_SEND:     if (r_hold_cnt == '0)  w_state_nxt = ST_WAIT_CLR;
            ST_WAIT_CLR: if (!ready)            w_state_nxt = ST_IDLE;
            default:                            w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tx_en_d = (r_state == ST_SEND) && (r_hold_cnt != '0);
        busy      = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_ADD;
            r_hold_cnt <= '0;
            r_tx_en    <= 1'b0;
            r_div_zero <= 1'b0;
            r_result   <= '0;
        end else begin
            r_tx_en <= w_tx_en_d;
            case (r_state)
                ST_IDLE: begin
                    if (ready) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_op       <= w_op_in;
                        r_div_zero <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    if (w_exec_done) begin
                        r_hold_cnt <= HOLD_LOAD;
                        case (r_op)
                            OP_ADD:  r_result <= r_a + r_b;
                            OP_SUB:  r_result <= r_a - r_b;
                            default: begin
                                if (w_div_by_zero) begin
                                    r_result   <= '1;
                                    r_div_zero <= 1'b1;
                                end else begin
                                    r_result   <= w_md_q;
                                end
                            end
                        endcase
                    end
                end
                ST_SEND: begin
                    if (r_hold_cnt != '0) r_hold_cnt <= r_hold_cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign result   = r_result;
    assign tx_en    = r_tx_en;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_serial_alu_core.sv
// tb/tb_serial_alu_core.sv - self-checking bench for serial_alu_core
module tb_serial_alu_core;

    localparam int W    = 8;
    localparam int HOLD = 4;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic [1:0]   op;
    logic [W-1:0] result;
    logic         tx_en;
    logic         busy;
    logic         div_zero;

    serial_alu_core #(
        .WIDTH          (W),
        .TX_HOLD_CYCLES (HOLD)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .op       (op),
        .result   (result),
        .tx_en    (tx_en),
        .busy     (busy),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_r;
        logic         exp_dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[16];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        case (o)
            2'd0:    return x + y;
            2'd1:    return x - y;
            2'd2:    return p[W-1:0];
            default: return (y == '0) ? '1 : x / y;
        endcase
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got;
        int   lat;
        int   hold;
        bit   seen;
        bit   stable;
        @(negedge clk);
        a = v.a; b = v.b; op = v.op; ready = 1'b1;
        e.r   = v.exp_r;
        e.dz  = v.exp_dz;
        e.lat = (v.op < 2'd2 || (v.op == 2'd3 && v.b == '0)) ? 2 : W + 1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        check("busy_after_capture", {31'd0, busy}, 32'd1);
        // Operands and op after the capture edge must not matter.
        op = ~v.op; a = ~v.a; b = v.b + 8'd1;
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 200 && !seen; k++) begin
            @(posedge clk); #1;
            if (tx_en) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        if (!seen) begin
            check("tx_en_timeout", 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end else if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check("latency", lat, got.lat);
            check("result", {24'd0, result}, {24'd0, got.r});
            check("div_zero", {31'd0, div_zero}, {31'd0, got.dz});
            ready  = 1'b0;
            hold   = 1;
            stable = 1'b1;
            for (int k = 0; k < 50 && tx_en; k++) begin
                @(posedge clk); #1;
                if (tx_en) begin
                    hold++;
                    if (result !== got.r) stable = 1'b0;
                end
            end
            check("tx_hold_cycles", hold, HOLD);
            check("result_stable", {31'd0, stable}, 32'd1);
        end
        ready = 1'b0;
        for (int k = 0; k < 10 && busy; k++) begin
            @(posedge clk); #1;
        end
        check("busy_release", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int   n_vec;
        int   rises;
        logic prev;
        vec_t v;

        vecs[0]  = '{2'd0, 8'hF0, 8'h20, 8'h10, 1'b0};
        vecs[1]  = '{2'd1, 8'd3,  8'd5,  8'hFE, 1'b0};
        vecs[2]  = '{2'd2, 8'd13, 8'd11, 8'h8F, 1'b0};
        vecs[3]  = '{2'd2, 8'hFF, 8'hFF, 8'h01, 1'b0};
        vecs[4]  = '{2'd3, 8'd200, 8'd7, 8'd28, 1'b0};
        vecs[5]  = '{2'd3, 8'd5,  8'd0,  8'hFF, 1'b1};
        vecs[6]  = '{2'd0, 8'd1,  8'd2,  8'd3,  1'b0};
        vecs[7]  = '{2'd3, 8'd7,  8'd200, 8'd0, 1'b0};
        vecs[8]  = '{2'd3, 8'hFF, 8'd1,  8'hFF, 1'b0};
        vecs[9]  = '{2'd2, 8'd0,  8'h5A, 8'd0,  1'b0};
        n_vec = 10;
        for (int i = 0; i < 6; i++) begin
            v.op = 2'($urandom_range(0, 3));
            v.a  = 8'($urandom_range(0, 255));
            v.b  = 8'($urandom_range(1, 255));
            v.exp_r  = model(v.op, v.a, v.b);
            v.exp_dz = 1'b0;
            vecs[n_vec] = v;
            n_vec++;
        end

        a = '0; b = '0; op = '0; ready = 1'b0; reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", {24'd0, result}, 32'd0);
        check("reset_tx_en", {31'd0, tx_en}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_div_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < n_vec; i++) run_vec(vecs[i]);

        // Reset while tx_en is held.
        @(negedge clk);
        a = 8'h33; b = 8'h44; op = 2'd0; ready = 1'b1;
        prev = 1'b0;
        for (int k = 0; k < 20 && !prev; k++) begin
            @(posedge clk); #1;
            prev = tx_en;
        end
        check("midsend_tx_seen", {31'd0, prev}, 32'd1);
        #3;
        reset_n = 1'b0;
        ready   = 1'b0;
        #1;
        check("midsend_tx_en", {31'd0, tx_en}, 32'd0);
        check("midsend_busy", {31'd0, busy}, 32'd0);
        check("midsend_result", {24'd0, result}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_idle", {31'd0, busy}, 32'd0);

        // ready held high through WAIT_CLR must yield one burst only.
        @(negedge clk);
        a = 8'd9; b = 8'd4; op = 2'd1; ready = 1'b1;
        rises = 0;
        prev  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (tx_en && !prev) rises++;
            prev = tx_en;
        end
        check("held_ready_one_burst", rises, 1);
        check("held_ready_result", {24'd0, result}, 32'd5);
        check("held_ready_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("held_ready_release", {31'd0, busy}, 32'd0);
        v = '{2'd2, 8'd6, 8'd7, 8'h2A, 1'b0};
        run_vec(v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
